// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a byte over valid/ready and serializes it as
// start bit, LSB-first data, optional even parity, and stop bit.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 serial_q;
    logic                 done_q;
    logic                 baud_last;
    logic                 bit_last;

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == BIT_W'(DATA_BITS - 1));

    // Ready is gated by rst directly so it is low on every reset cycle and
    // rises in the very first cycle after rst drops.
    assign tx_ready  = (state_q == IDLE) && !rst;
    assign tx_busy   = (state_q != IDLE);
    assign tx_serial = serial_q;
    assign tx_done   = done_q;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates take effect together at the clock edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (tx_valid) begin
                        shift_q  <= tx_data;
                        parity_q <= ^tx_data;
                        baud_q   <= '0;
                        serial_q <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_last) begin
                            if (PARITY_EN != 0) begin
                                serial_q <= parity_q;
                                state_q  <= PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= STOP;
                            end
                        end else begin
                            // Bit 1 of the pre-shift value is the next data bit.
                            bit_q    <= bit_q + BIT_W'(1);
                            shift_q  <= shift_q >> 1;
                            serial_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        serial_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule
